// File: rtl/dht_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dht_pkg
// Description : Shared state encoding, DHT11 phase timings and checksum helper
//               for the DHT11 frame generator.
// Revision    : 1.0 - initial release
// ============================================================================
package dht_pkg;

    // Line phases of one DHT11 frame (host start states only used when enabled)
    typedef enum logic [2:0] {
        GAP       = 3'd0,
        HOST_LOW  = 3'd1,
        HOST_REL  = 3'd2,
        RESP_LOW  = 3'd3,
        RESP_HIGH = 3'd4,
        BIT_LOW   = 3'd5,
        BIT_HIGH  = 3'd6,
        END_LOW   = 3'd7
    } dht_state_t;

    // Phase durations in microseconds
    localparam int T_HOST_LOW_US  = 18000;
    localparam int T_HOST_REL_US  = 30;
    localparam int T_RESP_US      = 80;
    localparam int T_BIT_LOW_US   = 50;
    localparam int T_BIT0_HIGH_US = 26;
    localparam int T_BIT1_HIGH_US = 70;
    localparam int T_END_LOW_US   = 50;
    localparam int FRAME_BITS     = 40;

    // Sum of the four data bytes, wrapping modulo 256
    function automatic logic [7:0] dht_checksum(
        input logic [7:0] hum_int,
        input logic [7:0] hum_dec,
        input logic [7:0] temp_int,
        input logic [7:0] temp_dec
    );
        logic [9:0] sum;
        sum = {2'b00, hum_int} + {2'b00, hum_dec} + {2'b00, temp_int} + {2'b00, temp_dec};
        return sum[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dht_us_tick.sv
`default_nettype none
// ============================================================================
// Module      : dht_us_tick
// Description : Microsecond prescaler. Pulses us_tick for one cycle every
//               US_DIV clocks; clr restarts the count so a phase begun on the
//               clearing edge lasts a whole number of microseconds.
// Revision    : 1.0 - initial release
// ============================================================================
module dht_us_tick #(
    parameter int US_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic us_tick
);

    localparam int            c_CW   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(US_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap  = (r_cnt == c_LAST);
    assign us_tick = w_wrap;

    // Count clocks within the current microsecond, restarting on wrap or clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dht_controller.sv
`default_nettype none
// ============================================================================
// Module      : dht_controller
// Description : DHT11 sensor-side frame generator. Emits gap, response
//               preamble, 40 data bits (MSB first, checksum last) and an end
//               pulse on 'signal', repeating forever.
//               Optional macro DHT_HOST_START_EN prepends the host start
//               pulse (18 ms low, 30 us high) to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module dht_controller
    import dht_pkg::*;
#(
    parameter int         CLK_FREQ_HZ  = 100_000_000,
    parameter logic [7:0] HUM_INT      = 8'd45,
    parameter logic [7:0] HUM_DEC      = 8'd0,
    parameter logic [7:0] TEMP_INT     = 8'd23,
    parameter logic [7:0] TEMP_DEC     = 8'd0,
    parameter int         FRAME_GAP_US = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic signal
);

    localparam int US_DIV   = CLK_FREQ_HZ / 1_000_000;
    // Microsecond counter spans the longest phase; the prescaler supplies the
    // US_DIV factor, so the pair covers the longest phase in clock cycles.
    localparam int c_MAX_US = (FRAME_GAP_US > T_HOST_LOW_US) ? FRAME_GAP_US : T_HOST_LOW_US;
    localparam int c_UW     = $clog2(c_MAX_US + 1);

    dht_state_t               r_state;
    logic [c_UW-1:0]          r_us;
    logic [5:0]               r_idx;
    logic [FRAME_BITS-1:0]    r_frame;
    logic                     r_signal;

    logic                     w_tick;
    logic                     w_done;
    logic [c_UW-1:0]          w_last;
    logic [7:0]               w_checksum;
    logic [FRAME_BITS-1:0]    w_frame;

    assign w_checksum = dht_checksum(HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC);
    assign w_frame    = {HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC, w_checksum};
    assign signal     = r_signal;

    dht_us_tick #(
        .US_DIV (US_DIV)
    ) u_us_tick (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_done),
        .us_tick (w_tick)
    );

    // Last microsecond count of the current phase; bit high width follows the bit value
    always_comb begin
        w_last = '0;
        case (r_state)
            GAP:       w_last = c_UW'(FRAME_GAP_US - 1);
`ifdef DHT_HOST_START_EN
            HOST_LOW:  w_last = c_UW'(T_HOST_LOW_US - 1);
            HOST_REL:  w_last = c_UW'(T_HOST_REL_US - 1);
`endif
            RESP_LOW:  w_last = c_UW'(T_RESP_US - 1);
            RESP_HIGH: w_last = c_UW'(T_RESP_US - 1);
            BIT_LOW:   w_last = c_UW'(T_BIT_LOW_US - 1);
            BIT_HIGH:  w_last = r_frame[FRAME_BITS-1] ? c_UW'(T_BIT1_HIGH_US - 1)
                                                      : c_UW'(T_BIT0_HIGH_US - 1);
            default:   w_last = c_UW'(T_END_LOW_US - 1);
        endcase
    end

    assign w_done = w_tick && (r_us == w_last);

    // Phase sequencer: advances on the final microsecond of each phase and
    // registers the line level for the phase being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= GAP;
            r_us     <= '0;
            r_idx    <= '0;
            r_frame  <= '0;
            r_signal <= 1'b1;
        end else if (w_done) begin
            r_us <= '0;
            case (r_state)
                GAP: begin
                    // Snapshot the frame so every bit of it is consistent
                    r_frame  <= w_frame;
                    r_signal <= 1'b0;
`ifdef DHT_HOST_START_EN
                    r_state  <= HOST_LOW;
`else
                    r_state  <= RESP_LOW;
`endif
                end
`ifdef DHT_HOST_START_EN
                HOST_LOW: begin
                    r_state  <= HOST_REL;
                    r_signal <= 1'b1;
                end
                HOST_REL: begin
                    r_state  <= RESP_LOW;
                    r_signal <= 1'b0;
                end
`endif
                RESP_LOW: begin
                    r_state  <= RESP_HIGH;
                    r_signal <= 1'b1;
                end
                RESP_HIGH: begin
                    r_state  <= BIT_LOW;
                    r_signal <= 1'b0;
                end
                BIT_LOW: begin
                    r_state  <= BIT_HIGH;
                    r_signal <= 1'b1;
                end
                BIT_HIGH: begin
                    r_signal <= 1'b0;
                    if (r_idx == 6'(FRAME_BITS - 1)) begin
                        r_state <= END_LOW;
                        r_idx   <= '0;
                    end else begin
                        r_state <= BIT_LOW;
                        r_idx   <= r_idx + 6'd1;
                        r_frame <= {r_frame[FRAME_BITS-2:0], 1'b0};
                    end
                end
                default: begin
                    r_state  <= GAP;
                    r_signal <= 1'b1;
                end
            endcase
        end else if (w_tick) begin
            r_us <= r_us + c_UW'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dht_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dht_controller
// Description : Self-checking bench for dht_controller. Expected line pulses
//               (level, width in cycles) are queued by the stimulus and
//               compared by a monitor that measures every run on the line.
//               A second instance checks checksum wrap by decoding its bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dht_controller;

`ifdef DHT_HOST_START_EN
    localparam int CLK_A = 1_000_000;
`else
    localparam int CLK_A = 2_000_000;
`endif
    localparam int UA     = CLK_A / 1_000_000;
    localparam int UB     = 1;
    localparam int GAP_US = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig_a;
    logic sig_b;

    always #5 clk = ~clk;

    dht_controller #(
        .CLK_FREQ_HZ  (CLK_A),
        .HUM_INT      (8'd45),
        .HUM_DEC      (8'd0),
        .TEMP_INT     (8'd23),
        .TEMP_DEC     (8'd0),
        .FRAME_GAP_US (GAP_US)
    ) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .signal (sig_a)
    );

    dht_controller #(
        .CLK_FREQ_HZ  (1_000_000),
        .HUM_INT      (8'd200),
        .HUM_DEC      (8'd0),
        .TEMP_INT     (8'd100),
        .TEMP_DEC     (8'd0),
        .FRAME_GAP_US (GAP_US)
    ) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .signal (sig_b)
    );

    typedef struct {
        logic  lvl;
        int    len;
        string name;
    } pulse_t;

    pulse_t     exp_q[$];
    logic [7:0] byte_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    bit         go_b   = 1'b0;

    task automatic chk_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic push(input logic l, input int n, input string s);
        pulse_t p;
        p.lvl  = l;
        p.len  = n;
        p.name = s;
        exp_q.push_back(p);
    endtask

    // Queue the expected pulses of one frame, starting with its gap
    task automatic push_frame(input logic [39:0] w, input int u);
        push(1'b1, GAP_US * u, "gap");
`ifdef DHT_HOST_START_EN
        push(1'b0, 18000 * u, "host_low");
        push(1'b1, 30 * u, "host_rel");
`endif
        push(1'b0, 80 * u, "resp_low");
        push(1'b1, 80 * u, "resp_high");
        for (int i = 39; i >= 0; i--) begin
            push(1'b0, 50 * u, $sformatf("bit%0d_low", i));
            push(1'b1, w[i] ? 70 * u : 26 * u, $sformatf("bit%0d_high", i));
        end
        push(1'b0, 50 * u, "end_low");
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d pulses outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: measure each constant-level run of DUT A and compare at its end
    initial begin
        bit   armed;
        logic prev;
        int   len;
        pulse_t p;
        armed = 1'b0;
        prev  = 1'b1;
        len   = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                armed = 1'b0;
            end else if (!armed) begin
                armed = 1'b1;
                prev  = sig_a;
                len   = 1;
            end else if (sig_a === prev) begin
                len++;
            end else begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_edge: run level %b width %0d, required no edge", prev, len);
                end else begin
                    p = exp_q.pop_front();
                    if (p.lvl !== prev || p.len != len) begin
                        errors++;
                        $display("FAIL %s: got level %b width %0d, required level %b width %0d",
                                 p.name, prev, len, p.lvl, p.len);
                    end
                end
                prev = sig_a;
                len  = 1;
            end
        end
    end

    // Decoder for DUT B: classify high widths into bits, compare each byte
    initial begin
        logic       p;
        int         len;
        int         nb;
        bit         inframe;
        logic [7:0] sh;
        logic [7:0] req;
        wait (go_b);
        p       = sig_b;
        len     = 0;
        nb      = 0;
        inframe = 1'b0;
        sh      = '0;
        while (byte_q.size() != 0) begin
            @(negedge clk);
            if (sig_b === p) begin
                len++;
            end else begin
                if (p === 1'b1) begin
                    if (len == 80 * UB) begin
                        inframe = 1'b1;
                        nb      = 0;
                    end else if (inframe && (len == 26 * UB || len == 70 * UB)) begin
                        sh = {sh[6:0], (len == 70 * UB)};
                        nb++;
                        if (nb == 8) begin
                            nb  = 0;
                            req = byte_q.pop_front();
                            checks++;
                            if (sh !== req) begin
                                errors++;
                                $display("FAIL wrap_byte: got 0x%02h, required 0x%02h", sh, req);
                            end
                        end
                    end else if (inframe) begin
                        checks++;
                        errors++;
                        $display("FAIL wrap_bit_width: got %0d cycles, required %0d or %0d",
                                 len, 26 * UB, 70 * UB);
                    end
                end
                p   = sig_b;
                len = 1;
            end
        end
    end

    // Global time limit so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        logic [39:0] word_a;
        int          rises;
        int          target;
        int          n;
        logic        p;

        word_a = 40'h2D_00_17_00_44;
        byte_q.push_back(8'hC8);
        byte_q.push_back(8'h00);
        byte_q.push_back(8'h64);
        byte_q.push_back(8'h00);
        byte_q.push_back(8'h2C);

        // Reset must force the line high before any clock edge
        #2 rst = 1'b0;
        #1 chk_bit("reset_async_a", sig_a, 1'b1);
        chk_bit("reset_async_b", sig_b, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_bit("reset_hold", sig_a, 1'b1);

        // Two complete frames after release: gap, preamble, bits, end pulse
        push_frame(word_a, UA);
        push_frame(word_a, UA);
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;
        go_b   = 1'b1;
        wait_drain(200_000, "two_frames");
        mon_en = 1'b0;

        // Advance into the high phase of bit index 20 of the next frame
`ifdef DHT_HOST_START_EN
        target = 23;
`else
        target = 22;
`endif
        rises = 0;
        n     = 0;
        p     = sig_a;
        while (rises < target && n < 100_000) begin
            @(negedge clk);
            if (sig_a === 1'b1 && p === 1'b0) rises++;
            p = sig_a;
            n++;
        end
        checks++;
        if (rises < target) begin
            errors++;
            $display("FAIL reach_bit20 timeout: got %0d rising edges, required %0d", rises, target);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_bit("midframe_reset", sig_a, 1'b1);
        repeat (2) @(posedge clk);

        // Full gap after release, then reset again inside the first low phase
        push(1'b1, GAP_US * UA, "gap_after_reset");
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;
        wait_drain(100_000, "gap_after_reset");
        mon_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_bit("low_phase_before_reset", sig_a, 1'b0);
        #2 rst = 1'b0;
        #1 chk_bit("lowphase_reset_async", sig_a, 1'b1);
        repeat (2) @(posedge clk);

        // Fresh frame from the gap, starting at bit 39
        push_frame(word_a, UA);
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;
        wait_drain(100_000, "fresh_frame");
        mon_en = 1'b0;

        checks++;
        if (byte_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_frame timeout: %0d bytes undecoded, required 0", byte_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
